// File: rtl/pwm_pkg.sv
// Shared PWM link definitions: the default period and the measurement FSM states.
package pwm_pkg;

  localparam int PWM_PERIOD = 256;

  typedef enum logic [1:0] {
    SYNC,
    HIGH,
    LOW
  } pwm_meas_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, followed by one more
// register so that rising and falling edges can be detected on the clean level.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= sig;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~prev_reg;
  assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/pwm8_meas.sv
// PWM duty-cycle receiver: times each full period rise-to-rise, reports the high
// time when the period matches, and falls back to a stuck-level verdict on timeout.
module pwm8_meas
  import pwm_pkg::*;
#(
  parameter int PERIOD  = PWM_PERIOD,
  parameter int TIMEOUT = 2 * PERIOD,
  parameter int DW      = $clog2(PERIOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PWM_in,
  output logic [DW-1:0] duty,
  output logic          valid,
  output logic          period_err,
  output logic          stuck
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT - 1);
  localparam logic [CW:0]   PERIOD_T   = (CW + 1)'(PERIOD);

  logic level;
  logic rise;
  logic fall;

  sync_edge u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .sig   (PWM_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  pwm_meas_state_t state_reg;
  logic [CW-1:0]   high_cnt_reg;
  logic [CW-1:0]   low_cnt_reg;
  logic [CW-1:0]   idle_cnt_reg;

  logic          edge_seen;
  logic          timeout_hit;
  logic [CW:0]   total;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign edge_seen   = rise | fall;
  // Fires only on the step into TIMEOUT; the counter then parks there, so no repeat.
  assign timeout_hit = !edge_seen && (idle_cnt_reg == TIMEOUT_M1);
  assign total       = {1'b0, high_cnt_reg} + {1'b0, low_cnt_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= SYNC;
      high_cnt_reg <= '0;
      low_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
      duty         <= '0;
      valid        <= 1'b0;
      period_err   <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      valid      <= 1'b0;
      period_err <= 1'b0;

      if (edge_seen) begin
        idle_cnt_reg <= '0;
        stuck        <= 1'b0;
      end else if (timeout_hit) begin
        idle_cnt_reg <= TIMEOUT_C;
      end else if (idle_cnt_reg != TIMEOUT_C) begin
        idle_cnt_reg <= sat_inc(idle_cnt_reg);
      end

      if (timeout_hit) begin
        duty      <= level ? '1 : '0;
        valid     <= 1'b1;
        stuck     <= 1'b1;
        state_reg <= SYNC;
      end else begin
        case (state_reg)
          SYNC: begin
            if (rise) begin
              high_cnt_reg <= CNT_ONE;
              state_reg    <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              low_cnt_reg <= CNT_ONE;
              state_reg   <= LOW;
            end else begin
              high_cnt_reg <= sat_inc(high_cnt_reg);
            end
          end
          LOW: begin
            if (rise) begin
              // A matching total implies low_cnt >= 1, so high_cnt always fits in DW bits.
              if (total == PERIOD_T) begin
                duty  <= high_cnt_reg[DW-1:0];
                valid <= 1'b1;
              end else begin
                period_err <= 1'b1;
              end
              high_cnt_reg <= CNT_ONE;
              state_reg    <= HIGH;
            end else begin
              low_cnt_reg <= sat_inc(low_cnt_reg);
            end
          end
          default: state_reg <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm8_meas.sv
// Directed bench for pwm8_meas: an edge-time model predicts every output each cycle,
// and literal checks at phase ends pin the model to hand-computed results.
module tb_pwm8_meas;

  localparam int PERIOD  = 256;
  localparam int TIMEOUT = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       PWM_in = 1'b0;
  logic [7:0] duty;
  logic       valid;
  logic       period_err;
  logic       stuck;

  always #5 clk = ~clk;

  pwm8_meas dut (
    .clk        (clk),
    .rst        (rst),
    .PWM_in     (PWM_in),
    .duty       (duty),
    .valid      (valid),
    .period_err (period_err),
    .stuck      (stuck)
  );

  int total = 0;
  int bad   = 0;

  // Model state: samples of PWM_in per clock, and clock indices of detected edges.
  int         m;
  int         last_evt;
  int         rise_m;
  int         fall_m;
  bit         armed;
  bit         have_fall;
  bit [3:0]   s;
  logic [7:0] exp_duty;
  bit         exp_valid;
  bit         exp_perr;
  bit         exp_stuck;

  int         vcnt = 0;
  int         pcnt = 0;
  logic [7:0] vlog[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // An input change sampled at clock m is seen as an edge two samples later;
  // its effect on the outputs is visible right after that clock.
  task automatic model_step();
    if (rst) begin
      m = 0; last_evt = 0; rise_m = 0; fall_m = 0;
      armed = 0; have_fall = 0; s = '0;
      exp_duty = 8'h00; exp_valid = 0; exp_perr = 0; exp_stuck = 0;
    end else begin
      m++;
      s = {s[2:0], PWM_in};
      exp_valid = 0;
      exp_perr  = 0;
      if (s[2] != s[3]) begin
        last_evt  = m;
        exp_stuck = 0;
        if (s[2]) begin
          if (armed && have_fall) begin
            if (m - rise_m == PERIOD) begin
              exp_duty  = 8'(fall_m - rise_m);
              exp_valid = 1;
            end else begin
              exp_perr = 1;
            end
          end
          armed = 1; have_fall = 0; rise_m = m;
        end else if (armed) begin
          have_fall = 1; fall_m = m;
        end
      end else if (m - last_evt == TIMEOUT) begin
        exp_duty  = s[2] ? 8'hFF : 8'h00;
        exp_valid = 1;
        exp_stuck = 1;
        armed = 0; have_fall = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("duty", duty, exp_duty);
    check("valid", valid, exp_valid);
    check("period_err", period_err, exp_perr);
    check("stuck", stuck, exp_stuck);
    if (valid) begin
      vcnt++;
      vlog.push_back(duty);
      $display("txn t=%0t valid duty=0x%02h stuck=%0d", $time, duty, stuck);
    end
    if (period_err) begin
      pcnt++;
      $display("txn t=%0t period_err duty=0x%02h", $time, duty);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic periods(input int h, input int l, input int n);
    repeat (n) begin
      PWM_in = 1'b1;
      run(h);
      PWM_in = 1'b0;
      run(l);
    end
  endtask

  initial begin
    int v0, p0, q0;
    logic [7:0] steps [7];
    steps = '{8'hBF, 8'hBF, 8'h7F, 8'h7F, 8'h3F, 8'h3F, 8'h01};

    rst = 1'b1; PWM_in = 1'b0;
    run(3);
    rst = 1'b0;
    run(10);
    check("reset_duty", duty, 0);
    check("reset_stuck", stuck, 0);

    // Nominal: first rise only arms, the next four close full periods.
    v0 = vcnt; p0 = pcnt;
    periods(191, 65, 5);
    check("nom_valids", vcnt - v0, 4);
    check("nom_perr", pcnt - p0, 0);
    check("nom_duty", duty, 8'hBF);

    // Reset in the middle of a high phase.
    PWM_in = 1'b1;
    run(50);
    rst = 1'b1;
    run(3);
    check("rst_duty", duty, 0);
    check("rst_valid", valid, 0);
    rst = 1'b0;
    v0 = vcnt;
    run(141);
    PWM_in = 1'b0;
    run(65);
    periods(191, 65, 3);
    check("rst_valids", vcnt - v0, 2);
    check("rst_duty_after", duty, 8'hBF);

    // Duty steps on period boundaries.
    q0 = vlog.size();
    periods(191, 65, 1);
    periods(127, 129, 2);
    periods(63, 193, 2);
    periods(1, 255, 2);
    check("step_count", vlog.size() - q0, 7);
    for (int i = 0; i < 7; i++) begin
      if (q0 + i < vlog.size()) check($sformatf("step_%0d", i), vlog[q0 + i], steps[i]);
    end

    // Bad period: first rise closes the last good 0x01 period.
    v0 = vcnt; p0 = pcnt;
    periods(100, 100, 4);
    check("bad_perr", pcnt - p0, 3);
    check("bad_valids", vcnt - v0, 1);
    check("bad_duty", duty, 8'h01);

    // Static high.
    v0 = vcnt; p0 = pcnt;
    PWM_in = 1'b1;
    run(600);
    check("hi_perr", pcnt - p0, 1);
    check("hi_valids", vcnt - v0, 1);
    check("hi_duty", duty, 8'hFF);
    check("hi_stuck", stuck, 1);

    // Recover: a fall clears stuck, two rises resume measurement.
    PWM_in = 1'b0;
    run(65);
    check("rec_stuck", stuck, 0);
    v0 = vcnt;
    periods(191, 65, 3);
    check("rec_valids", vcnt - v0, 2);
    check("rec_duty", duty, 8'hBF);

    // Static low.
    v0 = vcnt;
    run(600);
    check("lo_valids", vcnt - v0, 1);
    check("lo_duty", duty, 8'h00);
    check("lo_stuck", stuck, 1);

    run(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
